cloud_sprite_ctrl: RTL and testbench

Scheduler and arbiter that shares one synchronous cloud sprite ROM (58x32 px, 12-bit RGB, two animation frames) between NUM_CLOUDS cloud objects. For each pixel it holds cloud position, enable and drift-speed registers, resolves overlaps by fixed priority, and generates the ROM address. Per frame it advances horizontal drift and the animation frame. Sits between the VGA scan counter (col/row) and the pixel mux; replaces per-instance ROM copies.

---
 rtl/cloud_sprite_ctrl.sv | 145 ++++++++++++++
 tb/tb_cloud_sprite_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cloud_sprite_ctrl.sv
// Shares one synchronous cloud sprite ROM between NUM_CLOUDS clouds: per-pixel hit test,
// fixed-priority arbitration, ROM addressing, and per-frame drift/animation.
module cloud_sprite_ctrl #(
  parameter int          NUM_CLOUDS = 4,
  parameter int          CLOUD_W    = 58,
  parameter int          CLOUD_H    = 32,
  parameter int          SCREEN_W   = 640,
  parameter int          ANIM_DIV   = 30,
  parameter logic [11:0] TRANSP_KEY = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_idx,
  input  logic [9:0]  cfg_x,
  input  logic [9:0]  cfg_y,
  input  logic [1:0]  cfg_speed,
  input  logic        cfg_en,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        is_cloud,
  output logic [11:0] cloud_rgb,
  output logic [1:0]  hit_idx
);

  localparam logic [9:0]  CW        = 10'(CLOUD_W);
  localparam logic [9:0]  CH        = 10'(CLOUD_H);
  localparam logic [10:0] SW        = 11'(SCREEN_W);
  localparam logic [11:0] CW12      = 12'(CLOUD_W);
  localparam logic [11:0] FRAME_OFS = 12'(CLOUD_W * CLOUD_H);
  localparam logic [4:0]  ANIM_LAST = 5'(ANIM_DIV - 1);

  logic [9:0]            x_q   [NUM_CLOUDS];
  logic [9:0]            y_q   [NUM_CLOUDS];
  logic [1:0]            spd_q [NUM_CLOUDS];
  logic [NUM_CLOUDS-1:0] en_q;
  logic [4:0]            anim_cnt;
  logic                  frame_q;

  logic [9:0]            dx [NUM_CLOUDS];
  logic [9:0]            dy [NUM_CLOUDS];
  logic [NUM_CLOUDS-1:0] hit;
  logic [10:0]           drift_sum [NUM_CLOUDS];
  logic [9:0]            drift_x   [NUM_CLOUDS];

  logic                  hit_any;
  logic [1:0]            win_idx;
  logic [9:0]            win_dx;
  logic [9:0]            win_dy;
  logic [11:0]           addr_nxt;

  logic                  v1, v2;
  logic [1:0]            idx1, idx2;
  logic                  opaque;

  // Config handshake: a write is taken on any clk edge where cfg_valid && cfg_ready;
  // the master holds the request until then. Ready drops on frame_tick so drift wins.
  assign cfg_ready = !frame_tick;

  // Differences are only trusted when the >= guard holds, so underflow never hits.
  always_comb begin
    for (int i = 0; i < NUM_CLOUDS; i++) begin
      dx[i]        = col - x_q[i];
      dy[i]        = row - y_q[i];
      hit[i]       = en_q[i] && (col >= x_q[i]) && (dx[i] < CW) &&
                     (row >= y_q[i]) && (dy[i] < CH);
      drift_sum[i] = {1'b0, x_q[i]} + {9'd0, spd_q[i]};
      drift_x[i]   = (drift_sum[i] >= SW) ? 10'(drift_sum[i] - SW) : drift_sum[i][9:0];
    end
  end

  // Scan from the top index down so the lowest hitting index is left standing.
  always_comb begin
    hit_any = |hit;
    win_idx = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = 2'(i);
        win_dx  = dx[i];
        win_dy  = dy[i];
      end
    end
    addr_nxt = 12'(win_dy) * CW12 + 12'(win_dx) + (frame_q ? FRAME_OFS : 12'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
      end
      en_q     <= '0;
      anim_cnt <= '0;
      frame_q  <= 1'b0;
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        if (en_q[i]) x_q[i] <= drift_x[i];
      end
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt <= '0;
        frame_q  <= ~frame_q;
      end else begin
        anim_cnt <= anim_cnt + 5'd1;
      end
    end else if (cfg_valid && cfg_ready) begin
      x_q[cfg_idx]   <= ({1'b0, cfg_x} >= SW) ? 10'd0 : cfg_x;
      y_q[cfg_idx]   <= cfg_y;
      spd_q[cfg_idx] <= cfg_speed;
      en_q[cfg_idx]  <= cfg_en;
    end
  end

  assign opaque = v2 && (rom_data != TRANSP_KEY);

  // Three-stage pixel pipeline: address, ROM read alignment, output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      v1        <= 1'b0;
      idx1      <= '0;
      v2        <= 1'b0;
      idx2      <= '0;
      is_cloud  <= 1'b0;
      cloud_rgb <= '0;
      hit_idx   <= '0;
    end else begin
      rom_addr  <= hit_any ? addr_nxt : 12'd0;
      v1        <= hit_any;
      idx1      <= hit_any ? win_idx : 2'd0;
      v2        <= v1;
      idx2      <= idx1;
      is_cloud  <= opaque;
      cloud_rgb <= opaque ? rom_data : 12'd0;
      hit_idx   <= opaque ? idx2 : 2'd0;
    end
  end

endmodule

// File: tb/tb_cloud_sprite_ctrl.sv
// Scoreboard bench for cloud_sprite_ctrl: a reference model predicts rom_addr one cycle
// and the pixel outputs three cycles after each driven col/row.
module tb_cloud_sprite_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [9:0]  col, row;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_x, cfg_y;
  logic [1:0]  cfg_speed;
  logic        cfg_en;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic        is_cloud;
  logic [11:0] cloud_rgb;
  logic [1:0]  hit_idx;

  cloud_sprite_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .col(col), .row(row),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_speed(cfg_speed), .cfg_en(cfg_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .is_cloud(is_cloud), .cloud_rgb(cloud_rgb), .hit_idx(hit_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [11:0] rom_mem [4096];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [9:0] m_x [4];
  logic [9:0] m_y [4];
  logic [1:0] m_spd [4];
  logic [3:0] m_en;
  int         m_cnt;
  logic       m_frame;

  // scoreboard: {due cycle, is_cloud, hit_idx, rgb} and {due cycle, rom_addr}
  localparam int W = 47;
  logic [W-1:0] exp_q [$];
  logic [43:0]  addr_q [$];
  logic [W-1:0] mon_e;
  logic [43:0]  mon_a;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_spd[i] = '0;
    end
    m_en = '0; m_cnt = 0; m_frame = 1'b0;
  endtask

  task automatic model_write(input int idx, input int x, input int y, input int spd, input bit en);
    m_x[idx]   = (x >= 640) ? 10'd0 : 10'(x);
    m_y[idx]   = 10'(y);
    m_spd[idx] = 2'(spd);
    m_en[idx]  = en;
  endtask

  task automatic model_tick();
    int nx;
    for (int i = 0; i < 4; i++) begin
      if (m_en[i]) begin
        nx = int'(m_x[i]) + int'(m_spd[i]);
        if (nx >= 640) nx = nx - 640;
        m_x[i] = 10'(nx);
      end
    end
    if (m_cnt == 29) begin
      m_cnt = 0;
      m_frame = ~m_frame;
    end else begin
      m_cnt++;
    end
  endtask

  // returns {addr[11:0], is_cloud, hit_idx[1:0], rgb[11:0]}
  function automatic logic [26:0] model_pix(input logic [9:0] c, input logic [9:0] r);
    int dc, dr, a;
    bit hitf, op;
    logic [1:0] idx;
    logic [11:0] w;
    hitf = 0; a = 0; idx = '0;
    for (int i = 0; i < 4; i++) begin
      dc = int'(c) - int'(m_x[i]);
      dr = int'(r) - int'(m_y[i]);
      if (!hitf && m_en[i] && dc >= 0 && dc < 58 && dr >= 0 && dr < 32) begin
        hitf = 1;
        idx  = 2'(i);
        a    = dr * 58 + dc + (m_frame ? 1856 : 0);
      end
    end
    w  = rom_mem[a];
    op = hitf && (w != 12'hFFF);
    return {12'(a), op, (op ? idx : 2'd0), (op ? w : 12'd0)};
  endfunction

  // driver tasks
  task automatic drive_pix(input int c, input int r);
    logic [26:0] p;
    @(negedge clk);
    col = 10'(c);
    row = 10'(r);
    p = model_pix(col, row);
    addr_q.push_back({32'(cyc + 1), p[26:15]});
    exp_q.push_back({32'(cyc + 3), p[14:0]});
  endtask

  task automatic drive_pix_addr(input int c, input int r, input int exp_addr);
    drive_pix(c, r);
    @(negedge clk);
    check_eq("addr_const", 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic drive_pix_hit(input int c, input int r, input int exp_idx);
    drive_pix(c, r);
    repeat (3) @(negedge clk);
    check_eq("hit_idx_const", 32'(hit_idx), 32'(exp_idx));
    check_eq("is_cloud_const", 32'(is_cloud), 32'd1);
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int spd, input bit en);
    int n;
    bit acc;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_speed = 2'(spd); cfg_en = en;
    n = 0; acc = 0;
    do begin
      @(posedge clk);
      acc = cfg_ready;
      n++;
    end while (!acc && n < 20);
    total++;
    if (acc) model_write(idx, x, y, spd, en);
    else begin
      bad++;
      $display("FAIL cfg_timeout got=ready_low exp=accept within 20 cycles");
    end
    #1 cfg_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    model_tick();
    #1 frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    while (addr_q.size() > 0 && int'(addr_q[0][43:12]) <= cyc) begin
      mon_a = addr_q.pop_front();
      check_eq("rom_addr", 32'(rom_addr), 32'(mon_a[11:0]));
    end
    while (exp_q.size() > 0 && int'(exp_q[0][46:15]) <= cyc) begin
      mon_e = exp_q.pop_front();
      check_eq("is_cloud", 32'(is_cloud), 32'(mon_e[14]));
      check_eq("hit_idx", 32'(hit_idx), 32'(mon_e[13:12]));
      check_eq("cloud_rgb", 32'(cloud_rgb), 32'(mon_e[11:0]));
    end
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      rom_mem[a] = 12'(a * 37 + 5);
      if (rom_mem[a] == 12'hFFF) rom_mem[a] = 12'h123;
    end
    rst_n = 1'b0; frame_tick = 1'b0; col = '0; row = '0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_speed = '0; cfg_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_is_cloud", 32'(is_cloud), 32'd0);
    check_eq("rst_rgb", 32'(cloud_rgb), 32'd0);
    check_eq("rst_hit_idx", 32'(hit_idx), 32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    // single cloud: corners and just-outside edges
    cfg_write(0, 100, 50, 0, 1);
    drive_pix_addr(100, 50, 0);
    drive_pix_addr(157, 81, 1855);
    drive_pix(158, 81);
    drive_pix(157, 82);
    drive_pix(99, 50);
    drive_pix(100, 49);
    drive_pix(157, 81);
    idle(4);

    // animation frame toggles every 30 ticks
    repeat (30) tick();
    drive_pix_addr(100, 50, 1856);
    idle(4);
    repeat (30) tick();
    drive_pix_addr(100, 50, 0);
    idle(4);

    // overlap priority
    cfg_write(0, 200, 100, 0, 1);
    cfg_write(2, 200, 100, 0, 1);
    drive_pix_hit(210, 105, 0);
    cfg_write(0, 200, 100, 0, 0);
    drive_pix_hit(210, 105, 2);

    // drift wrap and config held across a frame_tick
    cfg_write(1, 638, 300, 3, 1);
    @(negedge clk);
    frame_tick = 1'b1;
    cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_x = 10'd400; cfg_y = 10'd200;
    cfg_speed = 2'd0; cfg_en = 1'b1;
    #1 check_eq("ready_on_tick", 32'(cfg_ready), 32'd0);
    @(posedge clk);
    model_tick();
    #1 frame_tick = 1'b0;
    #1 check_eq("ready_after_tick", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    model_write(3, 400, 200, 0, 1);
    #1 cfg_valid = 1'b0;
    drive_pix_hit(1, 300, 1);
    drive_pix(0, 300);
    drive_pix(638, 300);
    drive_pix_hit(405, 210, 3);

    // out-of-range x stored as 0
    cfg_write(2, 700, 400, 0, 1);
    drive_pix_hit(0, 400, 2);
    idle(4);

    // random scan around the clouds
    repeat (60) drive_pix($urandom_range(0, 460), $urandom_range(40, 440));
    idle(4);

    // transparent key
    rom_mem[585] = 12'hFFF;
    drive_pix(405, 210);
    repeat (3) @(negedge clk);
    check_eq("transp_is_cloud", 32'(is_cloud), 32'd0);
    check_eq("transp_rgb", 32'(cloud_rgb), 32'd0);
    check_eq("transp_hit_idx", 32'(hit_idx), 32'd0);
    idle(2);

    // reset mid-scan with opaque pixels in flight
    repeat (5) drive_pix(5, 305);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    model_reset();
    #1;
    check_eq("midrst_is_cloud", 32'(is_cloud), 32'd0);
    check_eq("midrst_rgb", 32'(cloud_rgb), 32'd0);
    check_eq("midrst_hit_idx", 32'(hit_idx), 32'd0);
    check_eq("midrst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_pix(5, 305);
    drive_pix(100, 50);
    idle(4);
    cfg_write(0, 100, 50, 0, 1);
    drive_pix_addr(100, 50, 0);
    idle(5);
    check_eq("drain", 32'(exp_q.size() + addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
